// File: rtl/crypton_axil_regs.sv
`default_nettype none
// ============================================================================
//  Module   : crypton_axil_regs
//  Purpose  : AXI4-Lite slave exposing four 32-bit read/write registers that
//             configure the Crypton core. Write address and write data are
//             accepted independently and committed together; reads run
//             concurrently with writes.
//  Ports    : S_AXI_ACLK / S_AXI_ARESET - clock, async active-high reset
//             S_AXI_AW* / S_AXI_W* / S_AXI_B* - write address, data, response
//             S_AXI_AR* / S_AXI_R*              - read address, data
//             regs_o     - flat register image, reg N at [32N+31:32N]
//             wr_pulse_o - bit N high for one cycle after reg N is written
//  Revision : 1.0 - initial release
// ============================================================================
module crypton_axil_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                              S_AXI_ACLK,
    input  logic                              S_AXI_ARESET,
    // write address channel
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    // write data channel
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    // write response channel
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    // read address channel
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    // read data channel
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    // crypto core side
    output logic [4*C_S_AXI_DATA_WIDTH-1:0]   regs_o,
    output logic [3:0]                        wr_pulse_o
);

    localparam int C_NUM_REGS = 4;
    localparam int C_STRB_W   = C_S_AXI_DATA_WIDTH / 8;

    // Write FSM. W_HOLD covers "one side held" and also the single cycle in
    // which both sides are held and the commit is about to happen.
    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_HOLD = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;

    logic [1:0]                      wstate_q;
    logic [1:0]                      wstate_d;
    logic                            rdy_en_q;
    logic                            aw_held_q;
    logic                            w_held_q;
    logic [1:0]                      awsel_q;
    logic [C_S_AXI_DATA_WIDTH-1:0]   wdata_q;
    logic [C_STRB_W-1:0]             wstrb_q;
    logic [3:0]                      wr_pulse_q;
    logic                            rvalid_q;
    logic [C_S_AXI_DATA_WIDTH-1:0]   rdata_q;

    logic                            w_aw_hs;
    logic                            w_w_hs;
    logic                            w_ar_hs;
    logic                            w_r_hs;
    logic                            w_commit;
    logic [1:0]                      w_sel;
    logic [C_S_AXI_DATA_WIDTH-1:0]   w_data;
    logic [C_STRB_W-1:0]             w_strb;
    logic [3:0]                      w_wen;
    logic [C_NUM_REGS-1:0][C_S_AXI_DATA_WIDTH-1:0] w_regs;

    // ------------------------------------------------------------------
    // Handshakes and ready generation. rdy_en_q keeps every ready low
    // while reset is asserted and raises them on the first edge after.
    // ------------------------------------------------------------------
    assign S_AXI_AWREADY = rdy_en_q & ~aw_held_q & (wstate_q != W_RESP);
    assign S_AXI_WREADY  = rdy_en_q & ~w_held_q  & (wstate_q != W_RESP);
    assign S_AXI_ARREADY = rdy_en_q & ~rvalid_q;

    assign w_aw_hs = S_AXI_AWVALID & S_AXI_AWREADY;
    assign w_w_hs  = S_AXI_WVALID  & S_AXI_WREADY;
    assign w_ar_hs = S_AXI_ARVALID & S_AXI_ARREADY;
    assign w_r_hs  = rvalid_q & S_AXI_RREADY;

    assign S_AXI_BVALID = (wstate_q == W_RESP);
    assign S_AXI_BRESP  = 2'b00;
    assign S_AXI_RVALID = rvalid_q;
    assign S_AXI_RDATA  = rdata_q;
    assign S_AXI_RRESP  = 2'b00;

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            rdy_en_q <= 1'b0;
        end else begin
            rdy_en_q <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Commit either from the held copies (both latched earlier) or straight
    // from the bus when AW and W arrive together in W_IDLE.
    // ------------------------------------------------------------------
    assign w_commit = ((wstate_q == W_IDLE) & w_aw_hs & w_w_hs) |
                      ((wstate_q == W_HOLD) & aw_held_q & w_held_q);
    assign w_sel    = aw_held_q ? awsel_q : S_AXI_AWADDR[3:2];
    assign w_data   = w_held_q  ? wdata_q : S_AXI_WDATA;
    assign w_strb   = w_held_q  ? wstrb_q : S_AXI_WSTRB;
    assign w_wen    = w_commit ? (4'b0001 << w_sel) : 4'b0000;

    always_comb begin
        wstate_d = wstate_q;
        case (wstate_q)
            W_IDLE: begin
                if (w_aw_hs && w_w_hs) begin
                    wstate_d = W_RESP;
                end else if (w_aw_hs || w_w_hs) begin
                    wstate_d = W_HOLD;
                end
            end
            W_HOLD: begin
                if (aw_held_q && w_held_q) begin
                    wstate_d = W_RESP;
                end
            end
            W_RESP: begin
                if (S_AXI_BREADY) begin
                    wstate_d = W_IDLE;
                end
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            wstate_q   <= W_IDLE;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            awsel_q    <= 2'b00;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            wr_pulse_q <= 4'b0000;
        end else begin
            wstate_q   <= wstate_d;
            wr_pulse_q <= w_wen;
            if (w_commit) begin
                aw_held_q <= 1'b0;
                w_held_q  <= 1'b0;
            end else begin
                if (w_aw_hs) begin
                    aw_held_q <= 1'b1;
                    awsel_q   <= S_AXI_AWADDR[3:2];
                end
                if (w_w_hs) begin
                    w_held_q <= 1'b1;
                    wdata_q  <= S_AXI_WDATA;
                    wstrb_q  <= S_AXI_WSTRB;
                end
            end
        end
    end

    assign wr_pulse_o = wr_pulse_q;

    // ------------------------------------------------------------------
    // Register file with byte-lane enables.
    // ------------------------------------------------------------------
    for (genvar n = 0; n < C_NUM_REGS; n++) begin : g_reg
        logic [C_S_AXI_DATA_WIDTH-1:0] reg_q;

        always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
            if (S_AXI_ARESET) begin
                reg_q <= '0;
            end else if (w_wen[n]) begin
                for (int b = 0; b < C_STRB_W; b++) begin
                    if (w_strb[b]) begin
                        reg_q[b*8 +: 8] <= w_data[b*8 +: 8];
                    end
                end
            end
        end

        assign w_regs[n] = reg_q;
    end

    assign regs_o = w_regs;

    // ------------------------------------------------------------------
    // Read channel. The sample uses the register contents before any commit
    // on the same edge, so a simultaneous write is not visible yet.
    // ------------------------------------------------------------------
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else if (w_ar_hs) begin
            rvalid_q <= 1'b1;
            rdata_q  <= w_regs[S_AXI_ARADDR[3:2]];
        end else if (w_r_hs) begin
            rvalid_q <= 1'b0;
        end
    end

    // Protection bits and the byte offset within a register carry no meaning.
    logic unused_ok;
    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR};

endmodule
`default_nettype wire
